// File: rtl/window_pkg.sv
// Shared state type, default widths and the periodic Hann coefficient generator
// used to fill the window coefficient ROM at elaboration time.
package window_pkg;

    typedef enum logic {S_DATA, S_PAD} state_t;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_COEF_W = 16;
    localparam int DEF_Q      = 15;

    localparam int     COS_FRAC = 30;
    localparam longint COS_ONE  = longint'(1) << COS_FRAC;
    localparam longint PI_FIX   = 64'sd3373259426;

    // cos(pi/2 * k/quarter) in COS_FRAC fixed point; the quadrant end points are exact
    function automatic longint cos_quarter(input longint k, input longint quarter);
        longint x, x2, term, sum;
        x    = (PI_FIX * k + quarter) / (2 * quarter);
        x2   = (x * x) >>> COS_FRAC;
        term = COS_ONE;
        sum  = COS_ONE;
        for (int i = 1; i <= 10; i++) begin
            term = -(((term * x2) >>> COS_FRAC) / longint'((2 * i - 1) * (2 * i)));
            sum  = sum + term;
        end
        if (k == 0)
            sum = COS_ONE;
        else if (k == quarter)
            sum = 0;
        return sum;
    endfunction

    function automatic longint hann_coef(input int n, input int len, input int q);
        longint quarter, m, r, c, amp;
        quarter = longint'(len / 4);
        m       = longint'(n % len);
        r       = m % quarter;
        case (m / quarter)
            0:       c = cos_quarter(r, quarter);
            1:       c = -cos_quarter(quarter - r, quarter);
            2:       c = -cos_quarter(r, quarter);
            default: c = cos_quarter(quarter - r, quarter);
        endcase
        amp = (longint'(1) << q) - 1;
        return (amp * (COS_ONE - c) + COS_ONE) / (2 * COS_ONE);
    endfunction

endpackage

// File: rtl/window_coef_rom.sv
// Periodic Hann window coefficient ROM, synchronous read with one cycle of latency.
module window_coef_rom
    import window_pkg::*;
#(
    parameter int FRAME_LEN = 256,
    parameter int COEF_W    = DEF_COEF_W,
    parameter int Q         = DEF_Q,
    localparam int AW       = $clog2(FRAME_LEN)
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic [AW-1:0]            addr,
    output logic signed [COEF_W-1:0] data
);

    logic signed [COEF_W-1:0] coef_table [FRAME_LEN];

    for (genvar g = 0; g < FRAME_LEN; g++) begin : g_coef
        localparam logic signed [COEF_W-1:0] COEF = COEF_W'(hann_coef(g, FRAME_LEN, Q));
        assign coef_table[g] = COEF;
    end

    always_ff @(posedge clk) begin
        if (en)
            data <= coef_table[addr];
    end

endmodule

// File: rtl/frame_window_pad.sv
// Hann-windows FRAME_LEN samples per frame and zero-pads each frame to FFT_LEN elements.
// Build option: define WINDOW_ROUND_EN to round half up before the Q shift instead of truncating.
module frame_window_pad
    import window_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int COEF_W    = DEF_COEF_W,
    parameter int Q         = DEF_Q,
    parameter int FRAME_LEN = 256,
    parameter int FFT_LEN   = 512,
    localparam int IW       = $clog2(FFT_LEN),
    localparam int AW       = $clog2(FRAME_LEN)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] sample_in,
    input  logic                     sample_valid,
    output logic                     sample_ready,
    output logic signed [DATA_W-1:0] sample_out,
    output logic                     sample_out_valid,
    input  logic                     sample_out_ready,
    output logic [IW-1:0]            out_idx,
    output logic                     frame_first,
    output logic                     frame_last
);

    localparam int PW  = DATA_W + COEF_W;
    localparam int PW1 = PW + 1;
    localparam logic [IW-1:0] LAST_DATA = IW'(FRAME_LEN - 1);
    localparam logic [IW-1:0] LAST_ELEM = IW'(FFT_LEN - 1);
    localparam logic signed [PW:0] SAT_MAX = {{(PW - DATA_W + 2){1'b0}}, {(DATA_W - 1){1'b1}}};
    localparam logic signed [PW:0] SAT_MIN = ~SAT_MAX;
`ifdef WINDOW_ROUND_EN
    localparam logic signed [PW:0] RND = {{(PW - Q + 1){1'b0}}, 1'b1, {(Q - 1){1'b0}}};
`else
    localparam logic signed [PW:0] RND = '0;
`endif

    state_t                   state, state_n;
    logic [IW-1:0]            idx, idx_n;
    logic                     en, take, inject;
    logic                     s1_valid;
    logic signed [DATA_W-1:0] s1_operand;
    logic [IW-1:0]            s1_idx;
    logic signed [COEF_W-1:0] coef;
    logic signed [PW:0]       product, shifted;
    logic signed [DATA_W-1:0] windowed;

    // A single enable stalls both stages together, so nothing is dropped or duplicated.
    assign en           = ~sample_out_valid | sample_out_ready;
    assign sample_ready = (state == S_DATA) && en;
    assign take         = sample_ready && sample_valid;
    assign inject       = (state == S_PAD) && en;

    always_comb begin
        state_n = state;
        idx_n   = idx;
        if (take) begin
            idx_n = idx + IW'(1);
            if (idx == LAST_DATA) begin
                if (FFT_LEN == FRAME_LEN)
                    idx_n = '0;
                else
                    state_n = S_PAD;
            end
        end else if (inject) begin
            idx_n = idx + IW'(1);
            if (idx == LAST_ELEM) begin
                idx_n   = '0;
                state_n = S_DATA;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_DATA;
            idx   <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_operand <= '0;
            s1_idx     <= '0;
        end else if (en) begin
            s1_valid   <= take | inject;
            s1_operand <= inject ? '0 : sample_in;
            s1_idx     <= idx;
        end
    end

    window_coef_rom #(
        .FRAME_LEN (FRAME_LEN),
        .COEF_W    (COEF_W),
        .Q         (Q)
    ) u_rom (
        .clk  (clk),
        .en   (en),
        .addr (idx[AW-1:0]),
        .data (coef)
    );

    // A zero pad operand makes the product zero whatever coefficient the ROM returns.
    always_comb begin
        product  = PW1'(s1_operand) * PW1'(coef) + RND;
        shifted  = product >>> Q;
        windowed = shifted[DATA_W-1:0];
        if (shifted > SAT_MAX)
            windowed = SAT_MAX[DATA_W-1:0];
        else if (shifted < SAT_MIN)
            windowed = SAT_MIN[DATA_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sample_out_valid <= 1'b0;
            sample_out       <= '0;
            out_idx          <= '0;
            frame_first      <= 1'b0;
            frame_last       <= 1'b0;
        end else if (en) begin
            sample_out_valid <= s1_valid;
            sample_out       <= windowed;
            out_idx          <= s1_idx;
            frame_first      <= s1_valid && (s1_idx == '0);
            frame_last       <= s1_valid && (s1_idx == LAST_ELEM);
        end
    end

endmodule

// File: tb/tb_frame_window_pad.sv
// Bench for frame_window_pad: random stimulus scored against a real-valued Hann window model.
`timescale 1ns/1ps
module tb_frame_window_pad;

    localparam int    DATA_W = 16;
    localparam int    Q      = 15;
    localparam int    FL     = 256;
    localparam int    FFT    = 512;
    localparam int    FL_B   = 64;
    localparam real   PI     = 3.14159265358979323846;

    typedef struct {
        longint val;
        int     idx;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     rst = 1'b1;
    logic signed [DATA_W-1:0] sample_in = '0;
    logic                     sample_valid = 1'b0;
    logic                     sample_ready;
    logic signed [DATA_W-1:0] sample_out;
    logic                     sample_out_valid;
    logic                     sample_out_ready = 1'b1;
    logic [8:0]               out_idx;
    logic                     frame_first, frame_last;

    logic signed [DATA_W-1:0] b_sample_in = '0;
    logic                     b_sample_valid = 1'b0;
    logic                     b_sample_ready;
    logic signed [DATA_W-1:0] b_sample_out;
    logic                     b_sample_out_valid;
    logic                     b_sample_out_ready = 1'b1;
    logic [5:0]               b_out_idx;
    logic                     b_frame_first, b_frame_last;

    frame_window_pad #(.FRAME_LEN(FL), .FFT_LEN(FFT)) dut (
        .clk              (clk),
        .rst              (rst),
        .sample_in        (sample_in),
        .sample_valid     (sample_valid),
        .sample_ready     (sample_ready),
        .sample_out       (sample_out),
        .sample_out_valid (sample_out_valid),
        .sample_out_ready (sample_out_ready),
        .out_idx          (out_idx),
        .frame_first      (frame_first),
        .frame_last       (frame_last)
    );

    frame_window_pad #(.FRAME_LEN(FL_B), .FFT_LEN(FL_B)) dut_eq (
        .clk              (clk),
        .rst              (rst),
        .sample_in        (b_sample_in),
        .sample_valid     (b_sample_valid),
        .sample_ready     (b_sample_ready),
        .sample_out       (b_sample_out),
        .sample_out_valid (b_sample_out_valid),
        .sample_out_ready (b_sample_out_ready),
        .out_idx          (b_out_idx),
        .frame_first      (b_frame_first),
        .frame_last       (b_frame_last)
    );

    int     vectors = 0;
    int     miscompares = 0;
    int     cycle = 0;
    bit     rand_ready = 1'b0;
    exp_t   exp_q[$];
    int     model_idx = 0;
    int     hs_count = 0;
    int     hs_first_cycle = 0;
    int     hs_last_cycle = 0;
    longint coef_a [FL];
    longint coef_b [FL_B];
    logic signed [DATA_W-1:0] captured [FFT];

    function automatic longint coef_ref(input int n, input int len);
        real c, v;
        c = $cos(2.0 * PI * n / len);
        v = 32767.0 * 0.5 * (1.0 - c);
        return longint'($rtoi(v + 0.5 + 1.0e-6));
    endfunction

    function automatic longint model_out(input longint s, input longint c);
        longint p, r;
        p = s * c;
`ifdef WINDOW_ROUND_EN
        p = p + (longint'(1) << (Q - 1));
`endif
        r = p >>> Q;
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
        return r;
    endfunction

    function automatic void push_sample(input longint s);
        exp_t e;
        e.val = model_out(s, coef_a[model_idx]);
        e.idx = model_idx;
        exp_q.push_back(e);
        model_idx++;
        if (model_idx == FL) begin
            for (int k = FL; k < FFT; k++) begin
                e.val = 0;
                e.idx = k;
                exp_q.push_back(e);
            end
            model_idx = 0;
        end
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            cycle <= cycle + 1;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            sample_out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output monitor: scores every handshake and checks that stalled outputs hold still.
    initial begin
        exp_t e;
        logic                     prev_stall = 1'b0;
        logic signed [DATA_W-1:0] prev_out = '0;
        logic [8:0]               prev_idx = '0;
        logic                     prev_first = 1'b0, prev_last = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    vectors++;
                    if (sample_out_valid !== 1'b1 || sample_out !== prev_out || out_idx !== prev_idx ||
                        frame_first !== prev_first || frame_last !== prev_last) begin
                        miscompares++;
                        $display("[TB] FAIL stall_hold: got v=%0b out=%0d idx=%0d ff=%0b fl=%0b, want v=1 out=%0d idx=%0d ff=%0b fl=%0b",
                                 sample_out_valid, sample_out, out_idx, frame_first, frame_last,
                                 prev_out, prev_idx, prev_first, prev_last);
                    end
                end
                if (sample_out_valid === 1'b1 && sample_out_ready === 1'b1) begin
                    hs_count++;
                    if (hs_count == 1) hs_first_cycle = cycle;
                    hs_last_cycle = cycle;
                    captured[out_idx] = sample_out;
                    vectors++;
                    if (exp_q.size() == 0) begin
                        miscompares++;
                        $display("[TB] FAIL unexpected_output: got out=%0d idx=%0d, want no output", sample_out, out_idx);
                    end else begin
                        e = exp_q.pop_front();
                        if (sample_out !== DATA_W'(e.val) || out_idx !== 9'(e.idx) ||
                            frame_first !== (e.idx == 0) || frame_last !== (e.idx == FFT - 1)) begin
                            miscompares++;
                            $display("[TB] FAIL out_elem: got out=%0d idx=%0d ff=%0b fl=%0b, want out=%0d idx=%0d ff=%0b fl=%0b",
                                     sample_out, out_idx, frame_first, frame_last,
                                     e.val, e.idx, (e.idx == 0), (e.idx == FFT - 1));
                        end
                    end
                end
                prev_stall = sample_out_valid && !sample_out_ready;
                prev_out   = sample_out;
                prev_idx   = out_idx;
                prev_first = frame_first;
                prev_last  = frame_last;
            end
        end
    end

    task automatic send_sample(input logic signed [DATA_W-1:0] s, input int gap);
        bit accepted = 1'b0;
        int waited = 0;
        repeat (gap) begin
            sample_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        sample_in    = s;
        sample_valid = 1'b1;
        while (!accepted && waited < 5000) begin
            @(negedge clk);
            accepted = (sample_ready === 1'b1);
            @(posedge clk);
            #1;
            waited++;
        end
        sample_valid = 1'b0;
        if (accepted) begin
            push_sample(longint'(s));
        end else begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL accept_timeout: got no handshake in %0d cycles, want acceptance", waited);
        end
    endtask

    task automatic wait_drain(input int want);
        int n = 0;
        while (exp_q.size() != 0 && n < 20000) begin
            @(posedge clk);
            n++;
        end
        repeat (6) @(posedge clk);
        #1;
        vectors++;
        if (exp_q.size() != 0 || hs_count != want) begin
            miscompares++;
            $display("[TB] FAIL drain_count: got %0d outputs (%0d still expected), want %0d",
                     hs_count, exp_q.size(), want);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (sample_out_valid !== 1'b0 || sample_out !== '0 || out_idx !== '0 ||
            frame_first !== 1'b0 || frame_last !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got v=%0b out=%0d idx=%0d ff=%0b fl=%0b, want all 0",
                     sample_out_valid, sample_out, out_idx, frame_first, frame_last);
        end
        vectors++;
        if (sample_ready !== 1'b1 || b_sample_out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_ready: got ready=%0b b_valid=%0b, want ready=1 b_valid=0",
                     sample_ready, b_sample_out_valid);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_ramp();
        rand_ready = 1'b0;
        hs_count   = 0;
        for (int i = 0; i < FL; i++) send_sample(DATA_W'(i), 0);
        wait_drain(FFT);
    endtask

    task automatic test_rounding();
        logic signed [DATA_W-1:0] s;
`ifdef WINDOW_ROUND_EN
        logic signed [DATA_W-1:0] want3 = 16'sd2;
`else
        logic signed [DATA_W-1:0] want3 = 16'sd1;
`endif
        rand_ready = 1'b0;
        hs_count   = 0;
        for (int i = 0; i < FFT; i++) captured[i] = 16'sh5a5a;
        for (int i = 0; i < FL; i++) begin
            s = DATA_W'($urandom);
            if (i == 64)  s = 16'sd3;
            if (i == 128) s = -16'sd32768;
            send_sample(s, 0);
        end
        wait_drain(FFT);
        vectors++;
        if (captured[64] !== want3) begin
            miscompares++;
            $display("[TB] FAIL round_idx64: got %0d, want %0d", captured[64], want3);
        end
        vectors++;
        if (captured[128] !== -16'sd32767) begin
            miscompares++;
            $display("[TB] FAIL min_idx128: got %0d, want -32767", captured[128]);
        end
        vectors++;
        if (captured[300] !== 16'sd0) begin
            miscompares++;
            $display("[TB] FAIL pad_zero: got %0d, want 0", captured[300]);
        end
    endtask

    task automatic test_backpressure();
        rand_ready = 1'b1;
        hs_count   = 0;
        for (int f = 0; f < 3; f++)
            for (int i = 0; i < FL; i++) send_sample(DATA_W'($urandom), 0);
        wait_drain(3 * FFT);
        rand_ready = 1'b0;
    endtask

    task automatic test_gapped();
        rand_ready = 1'b0;
        hs_count   = 0;
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < FL; i++) send_sample(DATA_W'($urandom), 2);
        wait_drain(2 * FFT);
    endtask

    task automatic test_back_to_back();
        rand_ready = 1'b0;
        hs_count   = 0;
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < FL; i++) send_sample(DATA_W'($urandom), 0);
        wait_drain(2 * FFT);
        vectors++;
        if (hs_last_cycle - hs_first_cycle !== 2 * FFT - 1) begin
            miscompares++;
            $display("[TB] FAIL no_bubbles: got span %0d cycles, want %0d",
                     hs_last_cycle - hs_first_cycle, 2 * FFT - 1);
        end
    endtask

    task automatic test_mid_frame_reset();
        rand_ready = 1'b0;
        hs_count   = 0;
        for (int i = 0; i < 100; i++) send_sample(DATA_W'($urandom), 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        vectors++;
        if (sample_out_valid !== 1'b0 || out_idx !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_frame: got v=%0b idx=%0d, want v=0 idx=0", sample_out_valid, out_idx);
        end
        exp_q.delete();
        model_idx = 0;
        hs_count  = 0;
        for (int i = 0; i < FL; i++) send_sample(DATA_W'($urandom), 0);
        wait_drain(FFT);
    endtask

    task automatic test_equal_len();
        exp_t bq[$];
        exp_t e;
        logic signed [DATA_W-1:0] s = '0;
        int sent = 0, got = 0, guard = 0;
        b_sample_out_ready = 1'b1;
        while (got < 2 * FL_B && guard < 1000) begin
            if (sent < 2 * FL_B) begin
                s = DATA_W'($urandom);
                b_sample_in    = s;
                b_sample_valid = 1'b1;
            end else begin
                b_sample_valid = 1'b0;
            end
            @(negedge clk);
            if (sent < 2 * FL_B) begin
                vectors++;
                if (b_sample_ready !== 1'b1) begin
                    miscompares++;
                    $display("[TB] FAIL eq_ready: got ready=%0b at sample %0d, want 1", b_sample_ready, sent);
                end else begin
                    e.val = model_out(longint'(s), coef_b[sent % FL_B]);
                    e.idx = sent % FL_B;
                    bq.push_back(e);
                    sent++;
                end
            end
            if (b_sample_out_valid === 1'b1) begin
                vectors++;
                got++;
                if (bq.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL eq_unexpected: got out=%0d idx=%0d, want no output", b_sample_out, b_out_idx);
                end else begin
                    e = bq.pop_front();
                    if (b_sample_out !== DATA_W'(e.val) || b_out_idx !== 6'(e.idx) ||
                        b_frame_first !== (e.idx == 0) || b_frame_last !== (e.idx == FL_B - 1)) begin
                        miscompares++;
                        $display("[TB] FAIL eq_elem: got out=%0d idx=%0d ff=%0b fl=%0b, want out=%0d idx=%0d ff=%0b fl=%0b",
                                 b_sample_out, b_out_idx, b_frame_first, b_frame_last,
                                 e.val, e.idx, (e.idx == 0), (e.idx == FL_B - 1));
                    end
                end
            end
            @(posedge clk);
            #1;
            guard++;
        end
        b_sample_valid = 1'b0;
        vectors++;
        if (got != 2 * FL_B || sent != 2 * FL_B) begin
            miscompares++;
            $display("[TB] FAIL eq_count: got %0d outputs from %0d samples, want %0d", got, sent, 2 * FL_B);
        end
    endtask

    initial begin
        for (int k = 0; k < FL; k++)   coef_a[k] = coef_ref(k, FL);
        for (int k = 0; k < FL_B; k++) coef_b[k] = coef_ref(k, FL_B);
        for (int k = 0; k < FFT; k++)  captured[k] = '0;
        $display("[TB] starting frame_window_pad bench");
        test_reset();
        test_ramp();
        test_rounding();
        test_backpressure();
        test_gapped();
        test_back_to_back();
        test_mid_frame_reset();
        test_equal_len();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
